// File: rtl/hb3_pwm_drive_if.sv
// Control and status signals between the HB3 PWM driver and its host.
// The host (master) owns the requests; the driver (slave) owns the bridge outputs.
interface hb3_pwm_drive_if;
   logic       enable;
   logic [7:0] duty;
   logic       dir_req;
   logic       EN;
   logic       DIR;
   logic       busy;
   logic       period_start;

   modport master (
      output enable,
      output duty,
      output dir_req,
      input  EN,
      input  DIR,
      input  busy,
      input  period_start
   );

   modport slave (
      input  enable,
      input  duty,
      input  dir_req,
      output EN,
      output DIR,
      output busy,
      output period_start
   );
endinterface

// File: rtl/hb3_pwm_drive.sv
// PWM and direction driver for the HB3 H-bridge PMOD.
// A dead-time FSM keeps EN low for DEAD_CLKS clocks before DIR is allowed to change.
module hb3_pwm_drive #(
   parameter int PRESCALE  = 196,
   parameter int DEAD_CLKS = 1000000
) (
   input  logic           clock,
   input  logic           reset,
   hb3_pwm_drive_if.slave bus
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DC_W = (DEAD_CLKS > 1) ? $clog2(DEAD_CLKS) : 1;
   localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [DC_W-1:0] DEAD_LAST = DC_W'(DEAD_CLKS - 1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DEAD = 2'd1,
      SWAP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PS_W-1:0] ps_q, ps_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [7:0]      duty_active_q, duty_active_d;
   logic [DC_W-1:0] dead_cnt_q, dead_cnt_d;
   logic            en_q, en_d;
   logic            dir_q, dir_d;
   logic            busy_q, busy_d;
   logic            period_start_q, period_start_d;

   logic            tick;
   logic            period_end;

   assign tick       = (ps_q == PS_LAST);
   assign period_end = tick && (pwm_cnt_q == 8'hFF);

   // Duty is latched only at the period boundary so a mid-period write never truncates a pulse.
   always_comb begin
      ps_d           = ps_q;
      pwm_cnt_d      = pwm_cnt_q;
      duty_active_d  = duty_active_q;
      period_start_d = 1'b0;

      if (tick) begin
         ps_d      = '0;
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
         ps_d = ps_q + PS_W'(1);
      end

      if (period_end) begin
         duty_active_d  = bus.duty;
         period_start_d = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      dir_d      = dir_q;

      unique case (state_q)
         RUN: begin
            if (bus.dir_req != dir_q) begin
               state_d    = DEAD;
               dead_cnt_d = '0;
            end
         end
         DEAD: begin
            if (dead_cnt_q == DEAD_LAST) begin
               state_d = SWAP;
            end else begin
               dead_cnt_d = dead_cnt_q + DC_W'(1);
            end
         end
         SWAP: begin
            dir_d   = bus.dir_req;
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Outputs follow the current state, so EN is still low in the first RUN cycle after a swap.
   always_comb begin
      en_d   = (state_q == RUN) && bus.enable && (pwm_cnt_q < duty_active_q);
      busy_d = (state_q == DEAD) || (state_q == SWAP);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= RUN;
         ps_q           <= '0;
         pwm_cnt_q      <= '0;
         duty_active_q  <= '0;
         dead_cnt_q     <= '0;
         en_q           <= 1'b0;
         dir_q          <= 1'b0;
         busy_q         <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ps_q           <= ps_d;
         pwm_cnt_q      <= pwm_cnt_d;
         duty_active_q  <= duty_active_d;
         dead_cnt_q     <= dead_cnt_d;
         en_q           <= en_d;
         dir_q          <= dir_d;
         busy_q         <= busy_d;
         period_start_q <= period_start_d;
      end
   end

   assign bus.EN           = en_q;
   assign bus.DIR          = dir_q;
   assign bus.busy         = busy_q;
   assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_hb3_pwm_drive.sv
// Self-checking bench for hb3_pwm_drive with a timeline-based reference model.
// Small PRESCALE and DEAD_CLKS keep PWM periods and dead times short.
module tb_hb3_pwm_drive;

   localparam int P    = 2;
   localparam int DEAD = 50;
   localparam int PER  = 256 * P;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   hb3_pwm_drive_if bus ();

   hb3_pwm_drive #(
      .PRESCALE  (P),
      .DEAD_CLKS (DEAD)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: edges since reset give the PWM position; a pending
   // direction change is just the edge number at which DIR gets resampled.
   int   k;
   bit   pending;
   int   swapEdge;
   bit   modelValid;
   logic mEn, mDir, mBusy, mPs;
   int   mDutyAct;

   initial modelValid = 1'b0;

   always @(posedge clock) begin
      int  pwmBefore;
      bit  boundary;
      if (reset) begin
         k          = 0;
         pending    = 1'b0;
         swapEdge   = -1;
         mEn        = 1'b0;
         mDir       = 1'b0;
         mBusy      = 1'b0;
         mPs        = 1'b0;
         mDutyAct   = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         pwmBefore = (k / P) % 256;
         boundary  = ((k % PER) == PER - 1);
         mEn   = !pending && bus.enable && (pwmBefore < mDutyAct);
         mBusy = pending;
         mPs   = boundary;
         if (boundary) mDutyAct = int'(bus.duty);
         if (pending) begin
            if (k == swapEdge) begin
               mDir    = bus.dir_req;
               pending = 1'b0;
            end
         end else if (bus.dir_req != mDir) begin
            pending  = 1'b1;
            swapEdge = k + DEAD + 1;
         end
         k++;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, all four outputs are compared against the model.
   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("modelEN", int'(bus.EN), int'(mEn));
         checkOutput("modelDIR", int'(bus.DIR), int'(mDir));
         checkOutput("modelBusy", int'(bus.busy), int'(mBusy));
         checkOutput("modelPeriodStart", int'(bus.period_start), int'(mPs));
      end
   end

   task automatic applyStimulus(input bit en, input logic [7:0] d, input bit dr);
      bus.enable  = en;
      bus.duty    = d;
      bus.dir_req = dr;
   endtask

   task automatic waitPeriodStart(input int maxCycles);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.period_start && n < maxCycles);
      if (!bus.period_start) begin
         checks++;
         failures++;
         $display("[TB] FAIL periodStartTimeout actual=none required=pulse within %0d clk", maxCycles);
      end
   endtask

   task automatic countWindow(input int n, output int enHigh, output int psCount);
      enHigh  = 0;
      psCount = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         enHigh  += int'(bus.EN);
         psCount += int'(bus.period_start);
      end
   endtask

   task automatic measureDirLatency(input logic target, input int already, output int lat);
      lat = already;
      while (bus.DIR != target && lat < 300) begin
         @(negedge clock);
         lat++;
      end
   endtask

   initial begin
      int c, c2, ps, lat;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      applyStimulus(1'b1, 8'd64, 1'b0);
      repeat (3) @(negedge clock);
      checkOutput("resetEN", int'(bus.EN), 0);
      checkOutput("resetDIR", int'(bus.DIR), 0);
      checkOutput("resetBusy", int'(bus.busy), 0);
      checkOutput("resetPeriodStart", int'(bus.period_start), 0);
      reset = 1'b0;

      $display("[TB] duty 64 waveform");
      waitPeriodStart(PER + 50);
      countWindow(PER, c, ps);
      checkOutput("duty64High", c, 128);
      checkOutput("duty64PeriodStarts", ps, 1);
      checkOutput("duty64Dir", int'(bus.DIR), 0);

      $display("[TB] duty 0 and 255, mid-period change");
      applyStimulus(1'b1, 8'd0, 1'b0);
      countWindow(PER, c, ps);
      checkOutput("dutyChangeLatency", c, 128);
      countWindow(PER, c, ps);
      checkOutput("duty0High", c, 0);
      applyStimulus(1'b1, 8'd255, 1'b0);
      countWindow(PER, c, ps);
      countWindow(PER, c, ps);
      checkOutput("duty255High", c, PER - 2);
      countWindow(200, c, ps);
      applyStimulus(1'b1, 8'd64, 1'b0);
      countWindow(PER - 200, c2, ps);
      checkOutput("midPeriodOldDuty", c + c2, PER - 2);
      countWindow(PER, c, ps);
      checkOutput("midPeriodNewDuty", c, 128);

      $display("[TB] direction change while EN high");
      applyStimulus(1'b1, 8'd128, 1'b0);
      countWindow(PER, c, ps);
      repeat (10) @(negedge clock);
      checkOutput("enHighBeforeTurn", int'(bus.EN), 1);
      applyStimulus(1'b1, 8'd128, 1'b1);
      repeat (2) @(negedge clock);
      checkOutput("enLowInDead", int'(bus.EN), 0);
      checkOutput("busyInDead", int'(bus.busy), 1);
      measureDirLatency(1'b1, 2, lat);
      checkOutput("dirLatency", lat, DEAD + 2);
      @(negedge clock);
      checkOutput("busyClear", int'(bus.busy), 0);
      waitPeriodStart(PER + 50);
      countWindow(PER, c, ps);
      checkOutput("pwmResumed", c, 256);

      $display("[TB] dir_req glitch during dead time");
      applyStimulus(1'b1, 8'd128, 1'b0);
      repeat (10) @(negedge clock);
      applyStimulus(1'b1, 8'd128, 1'b1);
      repeat (70) @(negedge clock);
      checkOutput("glitchDirHeld", int'(bus.DIR), 1);
      checkOutput("glitchBusyClear", int'(bus.busy), 0);

      $display("[TB] reset during dead time");
      reset = 1'b1;
      applyStimulus(1'b1, 8'd128, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(1'b1, 8'd128, 1'b1);
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midDeadResetEN", int'(bus.EN), 0);
      checkOutput("midDeadResetDIR", int'(bus.DIR), 0);
      checkOutput("midDeadResetBusy", int'(bus.busy), 0);
      reset = 1'b0;
      measureDirLatency(1'b1, 0, lat);
      checkOutput("dirLatencyAfterReset", lat, DEAD + 2);

      $display("[TB] enable low");
      applyStimulus(1'b0, 8'd128, 1'b1);
      waitPeriodStart(PER + 50);
      countWindow(2 * PER, c, ps);
      checkOutput("disabledEnHigh", c, 0);
      checkOutput("disabledPeriodStarts", ps, 2);
      applyStimulus(1'b0, 8'd128, 1'b0);
      measureDirLatency(1'b0, 0, lat);
      checkOutput("disabledDirLatency", lat, DEAD + 2);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 6000; i++) begin
         @(negedge clock);
         if ($urandom_range(299, 0) == 0) bus.duty = 8'($urandom_range(255, 0));
         if ($urandom_range(499, 0) == 0) bus.enable = 1'($urandom_range(1, 0));
         if ($urandom_range(149, 0) == 0) bus.dir_req = ~bus.dir_req;
         reset = ($urandom_range(1999, 0) == 0);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hb3_pwm_drive.md
Name: hb3_pwm_drive

Overview:
Generates the EN (PWM) and DIR outputs that drive the HB3 H-bridge PMOD. It is the drive-side counterpart of the SA/SB feedback frequency counter: software writes an 8-bit duty (0-255, the same scale as the feedback count) and a direction bit over AXI. A dead-time state machine guarantees EN is held low for a fixed interval before DIR changes, so the bridge never reverses while energised.

Parameters:
PRESCALE, 196, system clocks per PWM step (100 MHz / (196*256) ≈ 1.99 kHz PWM)
DEAD_CLKS, 1000000, clocks EN is held low before a DIR change (10 ms at 100 MHz)

Ports:
clock  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-high reset
enable  input  1  global motor enable; 0 forces EN low
duty  input  8  requested duty, 0 = off, 255 = 255/256 high
dir_req  input  1  requested direction
EN  output  1  PWM enable to HB3 (registered)
DIR  output  1  direction to HB3 (registered)
busy  output  1  high while a direction change is in progress (DEAD or SWAP)
period_start  output  1  one-clock pulse at the start of each PWM period

Behaviour:
- Reset (synchronous, active-high) sets EN=0, DIR=0, busy=0, period_start=0, the prescale counter to 0, pwm_cnt to 0, duty_active to 0, the dead counter to 0, and state to RUN. Reset asserted mid-dead-time abandons the change; DIR returns to 0.
- Prescaler ps counts 0..PRESCALE-1. tick = (ps == PRESCALE-1). ps wraps to 0 on tick.
- On tick, 8-bit pwm_cnt increments modulo 256. It runs in every state and is independent of enable.
- On tick with pwm_cnt == 255:
  - duty_active <= duty (duty sampled only at the period boundary, so there are no glitch pulses).
  - period_start pulses high for exactly one clock on the following cycle.
- EN <= (state == RUN) && enable && (pwm_cnt < duty_active), registered, so EN lags pwm_cnt by one clock.
  - duty 0: EN is constantly 0.
  - duty 255: EN is low for 1 step in 256.
- A new duty value takes effect at the next period boundary: worst case 256*PRESCALE clocks.
- FSM, state RUN:
  - If dir_req != DIR, go to DEAD and clear the dead counter.
  - Otherwise stay in RUN.
- FSM, state DEAD:
  - EN is forced low (EN falls within 2 clocks of the dir_req change).
  - The dead counter increments every clock.
  - When it reaches DEAD_CLKS-1, go to SWAP.
  - dir_req changes during DEAD are ignored; dead time always completes in full.
- FSM, state SWAP (1 clock):
  - DIR <= dir_req, sampled now.
  - If dir_req has returned to the old DIR, DIR is unchanged (a full dead time is still spent).
  - Next state is RUN.
- busy = (state == DEAD || state == SWAP), registered.
- DIR changes only in SWAP, never while EN is high. EN stays low in the first RUN cycle after SWAP, because EN is registered from state.
- Simultaneous duty boundary and direction change: duty_active still updates, but EN stays low until RUN resumes.
- enable = 0 does not stop the FSM. A direction change still performs dead time and swap.

Test Plan:
1. Reset, PRESCALE=2, duty=64, dir_req=0, enable=1 → after the first period_start, EN is high 64 steps (128 clk) and low 192 steps (384 clk) per 512-clk period; DIR=0.
2. Duty 0 then 255 (PRESCALE=2):
   - duty=0 → EN stays 0 indefinitely.
   - duty=255 → EN is low for exactly 2 clk per period.
   - A duty change mid-period → the old duty persists until the next period_start.
3. Direction change (DEAD_CLKS=50) while EN is high, dir_req 0→1 → EN=0 within 2 clk; busy=1; DIR toggles to 1 exactly 51 clk after entering DEAD; busy drops; PWM resumes.
4. Glitch during dead time: dir_req 0→1, then back to 0 after 10 clk → full 50-clk dead time; DIR stays 0; EN resumes.
5. Reset mid-DEAD with DIR=0 and target 1 → next clock EN=0, DIR=0, busy=0, state RUN. After reset releases, dir_req=1 still triggers a fresh full dead time.
6. enable=0 with duty=128 → EN is constantly 0; period_start keeps pulsing every 256*PRESCALE clk; a dir_req change still toggles DIR after DEAD_CLKS+1 clk.
